// File: rtl/lsu_mem_master.sv
// Load/store initiator for the MEM stage: turns RV32I byte-addressed loads/stores
// into word accesses, with lane extraction, read-modify-write for sub-word stores and error reporting.
module lsu_mem_master #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_WriteEn,
  output logic        mem_ReadEn,
  output logic [31:0] mem_Addr,
  output logic [31:0] mem_WriteData,
  input  logic [31:0] mem_ReadData
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic        accept, misaligned, out_of_range, illegal, req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext, merged;

  assign misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  assign out_of_range = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
  assign illegal      = req_we ? (req_funct3 > 3'b010)
                               : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
  assign req_err      = misaligned || out_of_range || illegal;
  assign accept       = req_valid && req_ready;

  always_comb begin
    lane_b   = mem_ReadData[{off_q, 3'b000} +: 8];
    lane_h   = off_q[1] ? mem_ReadData[31:16] : mem_ReadData[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_ext = {24'h0, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_ext = {16'h0, lane_h};
      default: load_ext = mem_ReadData;
    endcase
    // Sub-word store: overwrite only the addressed lane(s) of the fetched word
    merged = mem_ReadData;
    if (funct3_q[1:0] == 2'b00) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                        merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    req_ready     = (state_q == IDLE) && !rst;
    mem_WriteEn   = 1'b0;
    mem_ReadEn    = 1'b0;
    mem_Addr      = 32'h0;
    mem_WriteData = 32'h0;
    case (state_q)
      LOAD, RMW_RD: begin
        mem_ReadEn = 1'b1;
        mem_Addr   = 32'(idx_q);
      end
      WRITE: begin
        mem_WriteEn   = we_q;
        mem_Addr      = 32'(idx_q);
        mem_WriteData = wdata_q;
      end
      default: ;
    endcase
    // Reset must block any write still in flight this cycle
    if (rst) begin
      mem_WriteEn = 1'b0;
      mem_ReadEn  = 1'b0;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    off_d    = off_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = 32'h0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        idx_d    = req_addr[IDX_W+1:2];
        off_d    = req_addr[1:0];
        funct3_d = req_funct3;
        we_d     = req_we;
        wdata_d  = req_wdata;
        if (req_err) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else if (!req_we)              state_d = LOAD;
        else if (req_funct3 == 3'b010)     state_d = WRITE;
        else                               state_d = RMW_RD;
      end
      LOAD: begin
        rdata_d = load_ext;
        state_d = RESP;
      end
      RMW_RD: begin
        wdata_d = merged;
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      off_q    <= 2'b00;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      off_q    <= off_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: attached word memory plus a byte-level reference model
// of RV32I load/store semantics; each scenario task compares DUT responses to the model.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err, mem_WriteEn, mem_ReadEn;
  logic [31:0] rsp_rdata, mem_Addr, mem_WriteData, mem_ReadData;

  logic [31:0] mem    [0:1023];
  logic [31:0] refmem [0:1023];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] last_wdata = 32'h0;
  logic        clr_en = 1'b0;
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = 10'h0;
  logic [31:0] pre_val = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_WriteEn(mem_WriteEn), .mem_ReadEn(mem_ReadEn), .mem_Addr(mem_Addr),
    .mem_WriteData(mem_WriteData), .mem_ReadData(mem_ReadData)
  );

  assign mem_ReadData = (mem_Addr < 32'd1024) ? mem[mem_Addr[9:0]] : 32'h0;

  // Memory owns all its writes here so bench preloads and DUT stores never race
  always @(posedge clk) begin
    if (clr_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (mem_WriteEn && (mem_Addr < 32'd1024)) begin
      mem[mem_Addr[9:0]] <= mem_WriteData;
    end
    if (mem_WriteEn) begin
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= mem_WriteData;
    end
    if (mem_ReadEn) rd_cnt <= rd_cnt + 1;
  end

  function automatic void ref_access(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er,
                                     output int lat, output int nwr, output int nrd);
    int unsigned idx, off;
    logic [31:0] w, v, mask;
    idx = addr / 4;
    off = addr % 4;
    er  = ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) ||
          (f3 == 3'd2 && off != 0) || (idx >= 1024) ||
          (!we && (f3 == 3'd3 || f3 >= 3'd6)) || (we && f3 > 3'd2);
    rd = 32'h0; lat = 1; nwr = 0; nrd = 0;
    if (er) return;
    if (!we) begin
      w = refmem[idx];
      v = w >> (8 * off);
      case (f3)
        3'd0:    rd = ((v & 255) >= 128) ? ((v & 255) | 32'hFFFFFF00) : (v & 255);
        3'd4:    rd = v & 255;
        3'd1:    rd = ((v & 65535) >= 32768) ? ((v & 65535) | 32'hFFFF0000) : (v & 65535);
        3'd5:    rd = v & 65535;
        default: rd = w;
      endcase
      lat = 2; nrd = 1;
    end else if (f3 == 3'd2) begin
      refmem[idx] = wd;
      lat = 2; nwr = 1;
    end else begin
      mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
      refmem[idx] = (refmem[idx] & ~mask) | ((wd << (8 * off)) & mask);
      lat = 3; nwr = 1; nrd = 1;
    end
  endfunction

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
    refmem[idx] = val;
  endtask

  // Drives one request, waits for acceptance and its response (both bounded)
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output int nwr, output int nrd, output logic clean);
    int w0, r0, g;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    g = 0;
    while (!req_ready && g < 8) begin @(negedge clk); g++; end
    w0 = wr_cnt; r0 = rd_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 8);
    rd = rsp_rdata; er = rsp_err;
    nwr = wr_cnt - w0; nrd = rd_cnt - r0;
    @(negedge clk);
    clean = !rsp_valid && (rsp_rdata == 32'h0) && !rsp_err;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h4;
    clr_en = 1'b1;
    @(posedge clk); #1; clr_en = 1'b0;
    for (int i = 0; i < 1024; i++) refmem[i] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        mem_WriteEn !== 1'b0 || mem_ReadEn !== 1'b0 || mem_Addr !== 32'h0 || mem_WriteData !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: ready=%b valid=%b rdata=%h err=%b we=%b re=%b addr=%h wdata=%h, expected all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, mem_WriteEn, mem_ReadEn, mem_Addr, mem_WriteData);
    end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: ready=%b valid=%b, expected ready=1 valid=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_load;
    logic [2:0]  f3s  [5] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] ads  [5] = '{32'h4, 32'h8, 32'h8, 32'h8, 32'hA};
    logic [31:0] cons [5] = '{32'h9, 32'hFFFFFF80, 32'h80, 32'hFFFFF080, 32'h0};
    logic [31:0] rd, erd; logic er, eer, clean; int lat, nwr, nrd, elat, enwr, enrd;
    preload(10'd0, 32'd10);
    preload(10'd1, 32'd9);
    preload(10'd2, 32'h0000F080);
    for (int i = 0; i < 5; i++) begin
      ref_access(1'b0, f3s[i], ads[i], 32'h0, erd, eer, elat, enwr, enrd);
      issue(1'b0, f3s[i], ads[i], 32'h0, rd, er, lat, nwr, nrd, clean);
      checks++;
      if (rd !== erd || rd !== cons[i] || er !== eer || lat != elat || nwr != enwr || nrd != enrd || !clean) begin
        errors++;
        $display("[TB] FAIL load[%0d]: rdata=%h err=%b lat=%0d wr=%0d rd=%0d clean=%b, expected rdata=%h err=%b lat=%0d wr=%0d rd=%0d clean=1",
                 i, rd, er, lat, nwr, nrd, clean, cons[i], eer, elat, enwr, enrd);
      end
    end
  endtask

  task automatic test_store;
    logic [31:0] rd, erd; logic er, eer, clean; int lat, nwr, nrd, elat, enwr, enrd;
    ref_access(1'b1, 3'd0, 32'h5, 32'h123456AB, erd, eer, elat, enwr, enrd);
    issue(1'b1, 3'd0, 32'h5, 32'h123456AB, rd, er, lat, nwr, nrd, clean);
    checks++;
    if (rd !== erd || er !== eer || lat != elat || nwr != enwr || nrd != enrd || !clean) begin
      errors++;
      $display("[TB] FAIL sb_rsp: rdata=%h err=%b lat=%0d wr=%0d rd=%0d clean=%b, expected rdata=%h err=%b lat=%0d wr=%0d rd=%0d",
               rd, er, lat, nwr, nrd, clean, erd, eer, elat, enwr, enrd);
    end
    checks++;
    if (last_wdata !== 32'h0000AB09) begin
      errors++;
      $display("[TB] FAIL sb_wdata: got %h, expected 0000ab09", last_wdata);
    end
    ref_access(1'b1, 3'd1, 32'h6, 32'h0000BEEF, erd, eer, elat, enwr, enrd);
    issue(1'b1, 3'd1, 32'h6, 32'h0000BEEF, rd, er, lat, nwr, nrd, clean);
    checks++;
    if (rd !== erd || er !== eer || lat != elat || nwr != enwr || nrd != enrd || !clean) begin
      errors++;
      $display("[TB] FAIL sh_rsp: rdata=%h err=%b lat=%0d wr=%0d rd=%0d clean=%b, expected rdata=%h err=%b lat=%0d wr=%0d rd=%0d",
               rd, er, lat, nwr, nrd, clean, erd, eer, elat, enwr, enrd);
    end
    checks++;
    if (mem[1] !== 32'hBEEFAB09 || mem[1] !== refmem[1]) begin
      errors++;
      $display("[TB] FAIL sh_word: got %h, expected beefab09", mem[1]);
    end
  endtask

  task automatic test_errors;
    logic        wes [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s [6] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd1};
    logic [31:0] ads [6] = '{32'h3, 32'h2, 32'd4096, 32'h0, 32'h0, 32'h1};
    logic [31:0] rd, erd; logic er, eer, clean; int lat, nwr, nrd, elat, enwr, enrd;
    for (int i = 0; i < 6; i++) begin
      ref_access(wes[i], f3s[i], ads[i], 32'hDEADBEEF, erd, eer, elat, enwr, enrd);
      issue(wes[i], f3s[i], ads[i], 32'hDEADBEEF, rd, er, lat, nwr, nrd, clean);
      checks++;
      if (rd !== 32'h0 || er !== 1'b1 || er !== eer || lat != elat || nwr != 0 || nrd != 0 || !clean) begin
        errors++;
        $display("[TB] FAIL err[%0d]: rdata=%h err=%b lat=%0d wr=%0d rd=%0d clean=%b, expected rdata=0 err=1 lat=1 wr=0 rd=0",
                 i, rd, er, lat, nwr, nrd, clean);
      end
    end
    checks++;
    if (mem[0] !== refmem[0] || mem[1] !== refmem[1] || mem[2] !== refmem[2]) begin
      errors++;
      $display("[TB] FAIL err_mem: words %h %h %h, expected %h %h %h",
               mem[0], mem[1], mem[2], refmem[0], refmem[1], refmem[2]);
    end
  endtask

  task automatic test_reset_mid_write;
    int w0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h5; req_wdata = 32'h77;
    w0 = wr_cnt;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_WriteEn !== 1'b0 || mem_ReadEn !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_write_strobe: we=%b re=%b ready=%b, expected 0 0 0", mem_WriteEn, mem_ReadEn, req_ready);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1 ||
        mem_WriteEn !== 1'b0 || mem_ReadEn !== 1'b0 || mem_Addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_idle: valid=%b rdata=%h err=%b ready=%b we=%b re=%b addr=%h, expected 0 0 0 1 0 0 0",
               rsp_valid, rsp_rdata, rsp_err, req_ready, mem_WriteEn, mem_ReadEn, mem_Addr);
    end
    checks++;
    if (mem[1] !== refmem[1] || wr_cnt != w0) begin
      errors++;
      $display("[TB] FAIL rst_mem: word1=%h writes=%0d, expected %h and 0 writes", mem[1], wr_cnt - w0, refmem[1]);
    end
  endtask

  task automatic test_back_to_back;
    logic        wes [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [3] = '{3'd2, 3'd2, 3'd2};
    logic [31:0] ads [3] = '{32'h0, 32'h4, 32'h4};
    logic [31:0] wds [3] = '{32'h0, 32'h55, 32'h0};
    logic [31:0] erd [3]; logic eer [3];
    logic [31:0] grd [3]; logic ger [3];
    int elat, enwr, enrd, k, got, outstanding, accepts, busy_viol, extra;
    logic acc;
    preload(10'd0, 32'd10);
    for (int i = 0; i < 3; i++) ref_access(wes[i], f3s[i], ads[i], wds[i], erd[i], eer[i], elat, enwr, enrd);
    k = 0; got = 0; outstanding = 0; accepts = 0; busy_viol = 0; extra = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = wes[0]; req_funct3 = f3s[0]; req_addr = ads[0]; req_wdata = wds[0];
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      if (outstanding > 0 && req_ready) busy_viol++;
      if (rsp_valid) begin
        if (got < 3) begin grd[got] = rsp_rdata; ger[got] = rsp_err; end
        got++; outstanding--;
      end
      acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc) begin
        accepts++; outstanding++; k++;
        if (k < 3) begin
          req_we = wes[k]; req_funct3 = f3s[k]; req_addr = ads[k]; req_wdata = wds[k];
        end else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid) extra++;
      @(negedge clk);
    end
    checks++;
    if (busy_viol != 0 || accepts != 3 || got != 3 || extra != 0) begin
      errors++;
      $display("[TB] FAIL b2b_flow: busy_ready=%0d accepts=%0d responses=%0d extra=%0d, expected 0 3 3 0",
               busy_viol, accepts, got, extra);
    end
    for (int i = 0; i < 3 && i < got; i++) begin
      checks++;
      if (grd[i] !== erd[i] || ger[i] !== eer[i]) begin
        errors++;
        $display("[TB] FAIL b2b_rsp[%0d]: rdata=%h err=%b, expected rdata=%h err=%b", i, grd[i], ger[i], erd[i], eer[i]);
      end
    end
  endtask

  task automatic test_random;
    logic we; logic [2:0] f3; logic [31:0] addr, wd;
    logic [31:0] rd, erd; logic er, eer, clean; int lat, nwr, nrd, elat, enwr, enrd, r, bad;
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      wd = $urandom;
      r  = int'($urandom % 10);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = (1020 + ($urandom % 8)) * 4 + ($urandom % 4);
      else             addr = $urandom % 64;
      ref_access(we, f3, addr, wd, erd, eer, elat, enwr, enrd);
      issue(we, f3, addr, wd, rd, er, lat, nwr, nrd, clean);
      checks++;
      if (rd !== erd || er !== eer || lat != elat || nwr != enwr || nrd != enrd || !clean) begin
        errors++;
        $display("[TB] FAIL rand[%0d] we=%b f3=%0d addr=%h: rdata=%h err=%b lat=%0d wr=%0d rd=%0d clean=%b, expected rdata=%h err=%b lat=%0d wr=%0d rd=%0d",
                 i, we, f3, addr, rd, er, lat, nwr, nrd, clean, erd, eer, elat, enwr, enrd);
      end
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== refmem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL rand_mem: %0d words differ from model, expected 0", bad);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_store;
    test_errors;
    test_reset_mid_write;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-addressed data memory port (write enable, read enable, 32-bit address, write data in; combinational read data out) on behalf of the MEM pipeline stage.
- Converts RISC-V byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Performs byte-lane extraction with sign/zero extension.
- Sub-word stores use a read-modify-write sequence.
- Reports misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the attached memory; word index width is clog2(MEM_WORDS).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  pipeline presents a request
- req_ready  output  1  block accepts a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  valid with rsp_valid: misaligned, out-of-range or illegal funct3
- mem_WriteEn  output  1  memory write strobe
- mem_ReadEn  output  1  memory read enable
- mem_Addr  output  32  word index, zero-extended
- mem_WriteData  output  32  full word to write
- mem_ReadData  input  32  combinational read data for mem_Addr

Behaviour:
- Reset: state IDLE. rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, all latched request fields = 0.
- While rst = 1: req_ready, mem_WriteEn and mem_ReadEn are forced to 0 combinationally.
- Reset sampled in any state returns the block to IDLE. A write in progress in that cycle is suppressed.
- Accept: request accepted when req_valid && req_ready. req_ready = (state == IDLE) && !rst. Address, funct3, we and wdata are latched on accept.
- Word index = req_addr[31:2]. Byte offset = req_addr[1:0]. Byte order is little-endian: byte 0 = bits [7:0].
- Error checks on accept, in this order:
  - Halfword access with addr[0] = 1 is misaligned.
  - Word access with addr[1:0] != 0 is misaligned.
  - Word index >= MEM_WORDS is out of range.
  - Loads with funct3 011, 110 or 111 are illegal.
  - Stores with funct3 other than 000, 001 or 010 are illegal.
  - Any error -> RESP with rsp_err = 1; no mem strobe is ever asserted.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - Error -> RESP.
  - Load -> LOAD.
  - SW -> WRITE with mem_WriteData = wdata.
  - SB/SH -> RMW_RD.
- LOAD: mem_ReadEn = 1, mem_Addr = index. Capture mem_ReadData at the clock edge. Select the lane and extend:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
  - Next state RESP.
- RMW_RD: mem_ReadEn = 1, mem_Addr = index. Capture the word and merge wdata[7:0] or wdata[15:0] into the addressed lane(s); other lanes are preserved. Next state WRITE.
- WRITE: mem_WriteEn = 1, mem_Addr = index, mem_WriteData = merged/full word. Next state RESP.
- RESP: rsp_valid = 1 for exactly one cycle with registered rsp_rdata/rsp_err. Next state IDLE. rsp_rdata and rsp_err return to 0 when rsp_valid drops.
- Latency from accept edge to rsp_valid high:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
- Throughput: next accept is possible in the cycle after RESP. There is no rsp back-pressure; the pipeline always takes the response.
- Outside LOAD, RMW_RD and WRITE: mem_Addr = 0, mem_WriteData = 0, both strobes 0.
- Exactly one mem_WriteEn cycle per successful store. Zero write cycles for loads and errors.

Test Plan:
- Memory preloaded word0 = 10, word1 = 9. LW addr 0x4 -> rsp_valid 2 cycles after accept, rsp_rdata = 0x00000009, rsp_err = 0, one mem_ReadEn cycle, no WriteEn.
- Word2 = 0x0000F080. LB addr 0x8 -> 0xFFFFFF80. LBU addr 0x8 -> 0x00000080. LH addr 0x8 -> 0xFFFFF080. LHU addr 0xA -> 0x00000000.
- Word1 = 0x00000009. SB addr 0x5, wdata 0x123456AB -> RMW_RD, then WRITE with mem_WriteData = 0x0000AB09, rsp_valid 3 cycles after accept. Then SH addr 0x6, wdata 0xBEEF -> word1 = 0xBEEFAB09.
- LH addr 0x3, LW addr 0x2, SW addr 4096 (index 1024) -> rsp_err = 1 one cycle after accept, rsp_rdata = 0, no mem strobes, memory unchanged.
- SB addr 0x5 accepted, rst asserted during the WRITE cycle -> mem_WriteEn stays 0, word1 unchanged, next cycle IDLE with all outputs 0, req_ready = 1 after rst deasserts.
- Back-to-back: req_valid held high with LW 0x0 then SW 0x4 (0x55) then LW 0x4 -> req_ready low while busy; responses 10, store ack, 0x55 in order; no request is dropped or duplicated.
